seg_scan_ctl: RTL and testbench
===============================

# seg_scan_ctl

Parametrised, time-multiplexed seven-segment scan controller for 2 to 8 common-anode digits.
- Per-digit features: decimal points, blanking, leading-zero suppression and optional blinking.
- Display contents are double-buffered, so an update never tears mid-frame.
- Sits between application logic (counters, clocks, calculators) and the board's anode/segment pins, replacing the fixed 4-digit scanner.

## Interface
Parameters:
- NUM_DIGITS, 4, number of digits scanned (2..8)
- DWELL_BITS, 12, each digit is driven for 2^DWELL_BITS cycles
- BLINK_BITS, 6, blink phase toggles every 2^(BLINK_BITS-1) frames

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- digits_in  in  4*NUM_DIGITS  hex value per digit; digit k at [4k+3:4k]; digit NUM_DIGITS-1 is leftmost
- dp_in  in  NUM_DIGITS  decimal point on, per digit
- blank_in  in  NUM_DIGITS  force digit dark, per digit
- load  in  1  one-cycle strobe capturing digits_in/dp_in/blank_in into the pending buffer
- lz_en  in  1  leading-zero suppression enable (live, not buffered)
- blink_in  in  NUM_DIGITS  per-digit blink request (live, not buffered)
- dis  out  NUM_DIGITS  anode enables, active-low, at most one low
- segs  out  8  {a,b,c,d,e,f,g,dp}, active-low
- frame_tick  out  1  one-cycle pulse at each frame start
- load_ack  out  1  one-cycle pulse when pending data is committed to the active buffer

## Operation
Registers:
- DWELL_BITS dwell counter
- Scan index idx, counting NUM_DIGITS-1 down to 0, then wrapping
- Pending buffer plus pending flag
- Active buffer
- Output registers for dis and segs
- Blink frame counter (only when SCAN_BLINK_EN is defined)

Reset values:
- Dwell counter 0; idx = NUM_DIGITS-1
- Pending flag 0; active digits 0; active dp 0; active blank all ones (display dark until first commit)
- dis all ones; segs 8'hFF
- frame_tick 0; load_ack 0; blink counter 0

Scan and commit:
- The dwell counter increments every cycle.
- On wrap (D-1 -> 0, D = 2^DWELL_BITS), idx decrements; from 0 it wraps to NUM_DIGITS-1. That wrap is the frame boundary edge.
- load outside the boundary edge: pending <= inputs, pending flag <= 1. A later load overwrites the pending data (last wins).
- On the boundary edge with pending flag or load high: active <= (load ? inputs : pending), flag <= 0, load_ack <= 1.

Decode (from idx and the active buffer, registered into dis/segs):
- dis: bit idx low, all other bits high.
- segs[7:1]: standard hex glyphs 0-F. Examples: 0 = 7'b0000001, 1 = 7'b1001111, 8 = 7'b0000000, A = 7'b0001000, F = 7'b0111000.
- segs[0] = ~dp.

Blanking and suppression:
- Blanked digit: segs = 8'hFF (dp also off).
- Leading-zero suppression (lz_en = 1): digit k is suppressed if it and every higher digit hold value 0 and k != 0. A suppressed digit shows dp only if its dp bit is set.
- Priority: blank_in/blink blanking > suppression > glyph.

Arithmetic:
- All counters wrap modulo their width.
- idx is $clog2(NUM_DIGITS) bits wide and explicitly wraps at 0.

## Timing
- Frame length is NUM_DIGITS*D cycles.
- dis/segs lag idx/active by one cycle (registered outputs).
- First cycle after reset release: dis/segs are registered from idx = NUM_DIGITS-1 with the dark active buffer, so dis has bit NUM_DIGITS-1 low and segs = 8'hFF.
- frame_tick and load_ack are registered on the boundary edge. They are high during the first cycle of idx = NUM_DIGITS-1; dis shows the new frame one cycle later.
- Commit latency from load: at most one frame plus one cycle. load on the boundary edge itself commits on that edge.
- load_ack never pulses without a pending or simultaneous load.
- Reset asserted mid-frame: all state returns to reset values immediately and pending data is discarded.

## Configuration
- SCAN_BLINK_EN defined:
  - A BLINK_BITS frame counter increments on each frame boundary edge.
  - While its MSB is 1, digits with blink_in set are blanked (segs = 8'hFF).
- Undefined: no blink counter; blink_in is ignored; behaviour is otherwise identical.

## Test plan
Common bench settings: NUM_DIGITS=4, DWELL_BITS=2 (D=4), BLINK_BITS=2.
- Reset/scan: release rst, no load -> dis cycles 0111, 1011, 1101, 1110 every 4 cycles; segs = 8'hFF throughout; frame_tick every 16 cycles.
- Commit: load digits_in=16'h12A8, dp_in=4'b0010 mid-frame -> load_ack at next boundary. Next frame segs: 8'b10011111 (1), 8'b00100101 (2), 8'b00010000 (A with dp), 8'b00000001 (8).
- Tearing/last-wins: two loads in one frame (16'h1111 then 16'h2222) -> exactly one load_ack; whole next frame shows 2222. load on the boundary edge commits on that edge.
- Leading zero: active 16'h0070, lz_en=1 -> digits 3 and 2 segs = 8'hFF, digit 1 shows 7, digit 0 shows 0 (8'b00000011). Active 16'h0000 -> only digit 0 lit.
- Blink (SCAN_BLINK_EN): blink_in=4'b0001 -> digit 0 dark in frames 2-3 of each 4-frame period, lit in frames 0-1; other digits unaffected. Without the macro, digit 0 is always lit.
- Reset mid-operation: assert rst with pending data -> dis=4'hF and segs=8'hFF immediately; after release, no load_ack and the display stays dark.

Source files
------------

// File: rtl/seg_scan_ctl.sv
// rtl/seg_scan_ctl.sv - time-multiplexed common-anode seven-segment scan controller
// Define SCAN_BLINK_EN to build the per-digit blink frame counter.
module seg_scan_ctl #(
    parameter int NUM_DIGITS = 4,
    parameter int DWELL_BITS = 12,
    parameter int BLINK_BITS = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic                    load,
    input  logic                    lz_en,
    input  logic [NUM_DIGITS-1:0]   blink_in,
    output logic [NUM_DIGITS-1:0]   dis,
    output logic [7:0]              segs,
    output logic                    frame_tick,
    output logic                    load_ack
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NUM_DIGITS - 1);

    logic [DWELL_BITS-1:0]   dwell_q;
    logic [IDX_W-1:0]        idx_q;
    logic                    pend_flag_q;
    logic [4*NUM_DIGITS-1:0] pend_dig_q;
    logic [NUM_DIGITS-1:0]   pend_dp_q;
    logic [NUM_DIGITS-1:0]   pend_blank_q;
    logic [4*NUM_DIGITS-1:0] act_dig_q;
    logic [NUM_DIGITS-1:0]   act_dp_q;
    logic [NUM_DIGITS-1:0]   act_blank_q;
    logic [NUM_DIGITS-1:0]   dis_q;
    logic [7:0]              segs_q;
    logic                    frame_tick_q;
    logic                    load_ack_q;

    logic                    dwell_wrap;
    logic                    frame_edge;
    logic                    blink_dark;
    logic                    zero_run;
    logic [NUM_DIGITS-1:0]   sup_vec;
    logic [3:0]              cur_val;
    logic [NUM_DIGITS-1:0]   dis_d;
    logic [7:0]              segs_d;

    function automatic logic [6:0] hex_glyph(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'h0: g = 7'b0000001;
            4'h1: g = 7'b1001111;
            4'h2: g = 7'b0010010;
            4'h3: g = 7'b0000110;
            4'h4: g = 7'b1001100;
            4'h5: g = 7'b0100100;
            4'h6: g = 7'b0100000;
            4'h7: g = 7'b0001111;
            4'h8: g = 7'b0000000;
            4'h9: g = 7'b0000100;
            4'hA: g = 7'b0001000;
            4'hB: g = 7'b1100000;
            4'hC: g = 7'b0110001;
            4'hD: g = 7'b1000010;
            4'hE: g = 7'b0110000;
            default: g = 7'b0111000;
        endcase
        return g;
    endfunction

    assign dwell_wrap = &dwell_q;
    assign frame_edge = dwell_wrap && (idx_q == '0);

`ifdef SCAN_BLINK_EN
    logic [BLINK_BITS-1:0] blink_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt_q <= '0;
        end else if (frame_edge) begin
            blink_cnt_q <= blink_cnt_q + 1'b1;
        end
    end

    assign blink_dark = blink_cnt_q[BLINK_BITS-1] && blink_in[idx_q];
`else
    logic unused_blink;
    assign unused_blink = ^blink_in;
    assign blink_dark   = 1'b0;
`endif

    // A digit is suppressed when it and every digit to its left are zero; digit 0 always shows.
    always_comb begin
        zero_run = lz_en;
        sup_vec  = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zero_run = zero_run && (act_dig_q[4*k +: 4] == 4'h0);
            if (k != 0) begin
                sup_vec[k] = zero_run;
            end
        end
    end

    always_comb begin
        cur_val = act_dig_q[4*idx_q +: 4];
        dis_d   = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                dis_d[k] = 1'b0;
            end
        end
        if (act_blank_q[idx_q] || blink_dark) begin
            segs_d = 8'hFF;
        end else if (sup_vec[idx_q]) begin
            segs_d = {7'h7F, ~act_dp_q[idx_q]};
        end else begin
            segs_d = {hex_glyph(cur_val), ~act_dp_q[idx_q]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dwell_q      <= '0;
            idx_q        <= IDX_TOP;
            pend_flag_q  <= 1'b0;
            pend_dig_q   <= '0;
            pend_dp_q    <= '0;
            pend_blank_q <= '0;
            act_dig_q    <= '0;
            act_dp_q     <= '0;
            act_blank_q  <= '1;
            dis_q        <= '1;
            segs_q       <= 8'hFF;
            frame_tick_q <= 1'b0;
            load_ack_q   <= 1'b0;
        end else begin
            dwell_q <= dwell_q + 1'b1;
            if (dwell_wrap) begin
                idx_q <= (idx_q == '0) ? IDX_TOP : idx_q - 1'b1;
            end

            frame_tick_q <= frame_edge;
            load_ack_q   <= 1'b0;

            // Commits only happen at the frame boundary so a frame never mixes old and new data.
            if (frame_edge) begin
                pend_flag_q <= 1'b0;
                if (load || pend_flag_q) begin
                    act_dig_q   <= load ? digits_in : pend_dig_q;
                    act_dp_q    <= load ? dp_in     : pend_dp_q;
                    act_blank_q <= load ? blank_in  : pend_blank_q;
                    load_ack_q  <= 1'b1;
                end
            end else if (load) begin
                pend_dig_q   <= digits_in;
                pend_dp_q    <= dp_in;
                pend_blank_q <= blank_in;
                pend_flag_q  <= 1'b1;
            end

            dis_q  <= dis_d;
            segs_q <= segs_d;
        end
    end

    assign dis        = dis_q;
    assign segs       = segs_q;
    assign frame_tick = frame_tick_q;
    assign load_ack   = load_ack_q;

endmodule

// File: tb/tb_seg_scan_ctl.sv
// tb/tb_seg_scan_ctl.sv - randomized self-checking bench for seg_scan_ctl against a frame-level model
module tb_seg_scan_ctl;

    localparam int N  = 4;
    localparam int DB = 2;
    localparam int BB = 2;
    localparam int D  = 1 << DB;
    localparam int FR = N * D;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [15:0]   digits_in = '0;
    logic [3:0]    dp_in = '0;
    logic [3:0]    blank_in = '0;
    logic          load = 1'b0;
    logic          lz_en = 1'b0;
    logic [3:0]    blink_in = '0;
    logic [3:0]    dis;
    logic [7:0]    segs;
    logic          frame_tick;
    logic          load_ack;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [15:0] m_act_dig, m_pend_dig;
    logic [3:0]  m_act_dp, m_act_blank, m_pend_dp, m_pend_blank;
    bit          m_pflag;

    logic [6:0] glyph [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                               7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    seg_scan_ctl #(.NUM_DIGITS(N), .DWELL_BITS(DB), .BLINK_BITS(BB)) dut (
        .clk(clk), .rst(rst), .digits_in(digits_in), .dp_in(dp_in), .blank_in(blank_in),
        .load(load), .lz_en(lz_en), .blink_in(blink_in), .dis(dis), .segs(segs),
        .frame_tick(frame_tick), .load_ack(load_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_act_dig = '0; m_act_dp = '0; m_act_blank = '1;
        m_pend_dig = '0; m_pend_dp = '0; m_pend_blank = '0;
        m_pflag = 0;
        cyc = 0;
    endtask

    function automatic logic [7:0] exp_segs(int k);
        bit bl;
        bit sup;
        bl = 0;
`ifdef SCAN_BLINK_EN
        bl = blink_in[k] && (((cyc / FR) % (1 << BB)) >= (1 << (BB - 1)));
`endif
        sup = lz_en && (k != 0) && ((m_act_dig >> (4 * k)) == 16'h0);
        if (m_act_blank[k] || bl) return 8'hFF;
        if (sup) return {7'h7F, ~m_act_dp[k]};
        return {glyph[m_act_dig[4*k +: 4]], ~m_act_dp[k]};
    endfunction

    // One clock: predict the registered outputs from the pre-edge frame position, then compare.
    task automatic step();
        int k;
        logic [3:0] e_dis;
        logic [7:0] e_segs;
        bit bnd, e_ack;
        k = N - 1 - ((cyc / D) % N);
        e_dis = 4'hF;
        e_dis[k] = 1'b0;
        e_segs = exp_segs(k);
        bnd = (cyc % FR) == FR - 1;
        e_ack = bnd && (m_pflag || load);
        if (bnd) begin
            if (e_ack) begin
                m_act_dig   = load ? digits_in : m_pend_dig;
                m_act_dp    = load ? dp_in     : m_pend_dp;
                m_act_blank = load ? blank_in  : m_pend_blank;
            end
            m_pflag = 0;
        end else if (load) begin
            m_pend_dig = digits_in; m_pend_dp = dp_in; m_pend_blank = blank_in;
            m_pflag = 1;
        end
        @(posedge clk);
        #1;
        chk("dis", 32'(dis), 32'(e_dis));
        chk("segs", 32'(segs), 32'(e_segs));
        chk("frame_tick", 32'(frame_tick), 32'(bnd));
        chk("load_ack", 32'(load_ack), 32'(e_ack));
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic goto_phase(input int ph);
        for (int i = 0; i < FR && (cyc % FR) != ph; i++) step();
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
        digits_in = d; dp_in = dp; blank_in = bl; load = 1'b1;
        step();
        load = 1'b0;
    endtask

    initial begin
        logic [15:0] v;
        model_reset();
        #12;
        chk("rst_dis", 32'(dis), 32'h0000000F);
        chk("rst_segs", 32'(segs), 32'h000000FF);
        chk("rst_tick", 32'(frame_tick), 32'h0);
        chk("rst_ack", 32'(load_ack), 32'h0);
        rst = 1'b0;

        run(40);

        goto_phase(5);
        do_load(16'h12A8, 4'b0010, 4'b0000);
        run(40);

        goto_phase(3);
        do_load(16'h1111, 4'b0000, 4'b0000);
        run(4);
        do_load(16'h2222, 4'b0000, 4'b0000);
        run(30);

        goto_phase(FR - 1);
        do_load(16'h5E3C, 4'b1001, 4'b0000);
        run(20);

        lz_en = 1'b1;
        do_load(16'h0070, 4'b0000, 4'b0000);
        run(36);
        do_load(16'h0000, 4'b0000, 4'b0000);
        run(36);
        do_load(16'h0009, 4'b0100, 4'b0000);
        run(36);
        lz_en = 1'b0;

        do_load(16'h4321, 4'b0000, 4'b0000);
        blink_in = 4'b0001;
        run(6 * FR);

        for (int i = 0; i < 800; i++) begin
            if (i % 100 == 0) lz_en = 1'($urandom_range(0, 1));
            if (i % 50 == 0) blink_in = 4'($urandom);
            if ($urandom_range(0, 11) == 0) begin
                v = 16'($urandom);
                v = v >> (4 * $urandom_range(0, 4));
                do_load(v, 4'($urandom),
                        ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000);
            end else begin
                step();
            end
        end

        blink_in = 4'b0000;
        goto_phase(6);
        do_load(16'hBEEF, 4'b1111, 4'b0000);
        run(2);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_dis", 32'(dis), 32'h0000000F);
        chk("midrst_segs", 32'(segs), 32'h000000FF);
        chk("midrst_ack", 32'(load_ack), 32'h0);
        model_reset();
        #2;
        rst = 1'b0;
        run(3 * FR);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
